// File: rtl/sram_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// sram_mem_responder_pkg
// Shared definitions for the MEM-stage SRAM responder: FSM state encodings,
// default address map / SRAM geometry, and the byte-address to word-index
// helper used when a request is accepted.
// -----------------------------------------------------------------------------
package sram_mem_responder_pkg;

    // Default address map and SRAM geometry
    localparam int SMR_BASE_ADDR = 1024;   // byte address mapped to SRAM word 0
    localparam int SMR_SRAM_AW   = 18;     // half-word address width
    localparam int SMR_SRAM_WAIT = 2;      // cycles per half-word phase

    // FSM state encodings
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WR_LO = 3'd1;
    localparam logic [2:0] ST_WR_HI = 3'd2;
    localparam logic [2:0] ST_RD_LO = 3'd3;
    localparam logic [2:0] ST_RD_HI = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // 32-bit word index of a byte address relative to the SRAM base.
    // Out-of-range addresses simply wrap once the caller truncates the result.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                               input logic [31:0] base_addr);
        return (byte_addr - base_addr) >> 2;
    endfunction

endpackage

// File: rtl/sram_mem_responder.sv
// -----------------------------------------------------------------------------
// sram_mem_responder
// Memory-side responder for the MEM stage. Accepts a 32-bit load or store,
// serves it over a 16-bit asynchronous SRAM as two half-word phases (low half
// first), and returns load data plus a ready flag. The core holds the request
// and freezes its pipeline while ready is low.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   MEM_R_EN     in   load request (held until ready)
//   MEM_W_EN     in   store request (held until ready); wins over a load
//   addr         in   32-bit byte address
//   wdata        in   32-bit store data
//   rdata        out  32-bit load data, held until the next load completes
//   ready        out  high when idle with no request, or in the finishing cycle
//   sram_addr    out  half-word address
//   sram_dq_out  out  write half-word
//   sram_dq_oe   out  DQ drive enable (the board top builds the tri-state:
//                     sram_dq = sram_dq_oe ? sram_dq_out : 16'bz)
//   sram_dq_in   in   read half-word
//   sram_we_n    out  write strobe, active low
//   sram_oe_n    out  output enable, active low
//   sram_ce_n    out  chip enable, active low
// -----------------------------------------------------------------------------
module sram_mem_responder
    import sram_mem_responder_pkg::*;
#(
    parameter int BASE_ADDR = SMR_BASE_ADDR,
    parameter int SRAM_AW   = SMR_SRAM_AW,
    parameter int SRAM_WAIT = SMR_SRAM_WAIT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               sram_ce_n
);

    localparam int CW = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
    localparam int WW = SRAM_AW - 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SRAM_WAIT - 1);

    logic [2:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [WW-1:0]      r_word;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;
    logic [SRAM_AW-1:0] r_sram_addr;
    logic [15:0]        r_dq_out;
    logic               r_dq_oe;
    logic               r_we_n;
    logic               r_oe_n;
    logic               r_ce_n;

    logic [2:0]         w_state_nxt;
    logic [CW-1:0]      w_cnt_nxt;
    logic [WW-1:0]      w_word_nxt;
    logic [31:0]        w_wdata_nxt;
    logic [WW-1:0]      w_req_word;
    logic               w_last;
    logic [SRAM_AW-1:0] w_addr_nxt;
    logic [15:0]        w_dq_nxt;
    logic               w_dq_oe_nxt;
    logic               w_we_n_nxt;
    logic               w_oe_n_nxt;
    logic               w_ce_n_nxt;
    logic               w_ready;

    assign w_req_word = WW'(word_index(addr, 32'(BASE_ADDR)));
    assign w_last     = (r_cnt == CNT_LAST);

    // Next-state, phase counter and request-operand capture
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_word_nxt  = r_word;
        w_wdata_nxt = r_wdata;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = {CW{1'b0}};
                // Operands are frozen here so the core may change them mid-flight
                if (MEM_W_EN) begin
                    w_state_nxt = ST_WR_LO;
                    w_word_nxt  = w_req_word;
                    w_wdata_nxt = wdata;
                end else if (MEM_R_EN) begin
                    w_state_nxt = ST_RD_LO;
                    w_word_nxt  = w_req_word;
                    w_wdata_nxt = wdata;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WR_LO, ST_WR_HI, ST_RD_LO, ST_RD_HI: begin
                if (w_last) begin
                    w_cnt_nxt = {CW{1'b0}};
                    case (r_state)
                        ST_WR_LO: w_state_nxt = ST_WR_HI;
                        ST_RD_LO: w_state_nxt = ST_RD_HI;
                        default:  w_state_nxt = ST_DONE;
                    endcase
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = {CW{1'b0}};
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = {CW{1'b0}};
            end
        endcase
    end

    // SRAM bus values for the coming cycle, decoded from the next state so the
    // registered bus lines up exactly with each phase
    always_comb begin
        w_addr_nxt  = r_sram_addr;
        w_dq_nxt    = r_dq_out;
        w_dq_oe_nxt = 1'b0;
        w_we_n_nxt  = 1'b1;
        w_oe_n_nxt  = 1'b1;
        w_ce_n_nxt  = 1'b1;
        case (w_state_nxt)
            ST_WR_LO: begin
                w_addr_nxt  = {w_word_nxt, 1'b0};
                w_dq_nxt    = w_wdata_nxt[15:0];
                w_dq_oe_nxt = 1'b1;
                w_we_n_nxt  = 1'b0;
                w_ce_n_nxt  = 1'b0;
            end
            ST_WR_HI: begin
                w_addr_nxt  = {w_word_nxt, 1'b1};
                w_dq_nxt    = w_wdata_nxt[31:16];
                w_dq_oe_nxt = 1'b1;
                w_we_n_nxt  = 1'b0;
                w_ce_n_nxt  = 1'b0;
            end
            ST_RD_LO: begin
                w_addr_nxt = {w_word_nxt, 1'b0};
                w_oe_n_nxt = 1'b0;
                w_ce_n_nxt = 1'b0;
            end
            ST_RD_HI: begin
                w_addr_nxt = {w_word_nxt, 1'b1};
                w_oe_n_nxt = 1'b0;
                w_ce_n_nxt = 1'b0;
            end
            default: begin
                w_dq_oe_nxt = 1'b0;
            end
        endcase
    end

    // Ready: idle with nothing asked, or the single finishing cycle
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            ST_IDLE: w_ready = ~(MEM_R_EN | MEM_W_EN);
            ST_DONE: w_ready = 1'b1;
            default: w_ready = 1'b0;
        endcase
    end

    // FSM state, counter and latched operands
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= {CW{1'b0}};
            r_word  <= {WW{1'b0}};
            r_wdata <= 32'h0000_0000;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_word  <= w_word_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    // Registered SRAM bus
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sram_addr <= {SRAM_AW{1'b0}};
            r_dq_out    <= 16'h0000;
            r_dq_oe     <= 1'b0;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_ce_n      <= 1'b1;
        end else begin
            r_sram_addr <= w_addr_nxt;
            r_dq_out    <= w_dq_nxt;
            r_dq_oe     <= w_dq_oe_nxt;
            r_we_n      <= w_we_n_nxt;
            r_oe_n      <= w_oe_n_nxt;
            r_ce_n      <= w_ce_n_nxt;
        end
    end

    // Load data capture on the last cycle of each read phase, when the
    // asynchronous SRAM output has had the full phase to settle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= 32'h0000_0000;
        end else if ((r_state == ST_RD_LO) && w_last) begin
            r_rdata[15:0] <= sram_dq_in;
        end else if ((r_state == ST_RD_HI) && w_last) begin
            r_rdata[31:16] <= sram_dq_in;
        end else begin
            r_rdata <= r_rdata;
        end
    end

    assign rdata       = r_rdata;
    assign ready       = w_ready;
    assign sram_addr   = r_sram_addr;
    assign sram_dq_out = r_dq_out;
    assign sram_dq_oe  = r_dq_oe;
    assign sram_we_n   = r_we_n;
    assign sram_oe_n   = r_oe_n;
    assign sram_ce_n   = r_ce_n;

endmodule

// File: tb/tb_sram_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_sram_mem_responder
// Directed bench for sram_mem_responder with a behavioural asynchronous SRAM
// (64 half-words, combinational read, write on the clock edge while CE/WE low).
// -----------------------------------------------------------------------------
module tb_sram_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic        sram_ce_n;

    logic [15:0] mem [0:63];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_mem_responder dut (
        .clk         (clk),
        .rst         (rst),
        .MEM_R_EN    (MEM_R_EN),
        .MEM_W_EN    (MEM_W_EN),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n),
        .sram_oe_n   (sram_oe_n),
        .sram_ce_n   (sram_ce_n)
    );

    // Behavioural SRAM
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[5:0]] : 16'h0000;

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) mem[sram_addr[5:0]] <= sram_dq_out;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one request starting right after a rising edge. Optionally, at the
    // start of cycle chg_cyc, drops both enables and scrambles addr/wdata.
    task automatic run_txn(input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d,
                           input int chg_cyc, input logic [31:0] a2,
                           output int lat, output int we_low, output int oe_low,
                           output int drv, output logic [31:0] rd);
        MEM_R_EN = r;
        MEM_W_EN = w;
        addr     = a;
        wdata    = d;
        lat      = -1;
        we_low   = 0;
        oe_low   = 0;
        drv      = 0;
        rd       = 32'h0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc == chg_cyc) begin
                MEM_R_EN = 1'b0;
                MEM_W_EN = 1'b0;
                addr     = a2;
                wdata    = 32'h0000_0000;
            end
            @(negedge clk);
            if (!sram_we_n) we_low++;
            if (!sram_oe_n) oe_low++;
            if (sram_dq_oe) drv++;
            if (ready) begin
                lat = cyc;
                rd  = rdata;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, we_low, oe_low, drv, rdy_cnt, ce_low;
        logic [31:0] rd;

        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        rst      = 1'b0;
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
        addr     = 32'h0;
        wdata    = 32'h0;
        repeat (3) @(posedge clk);

        // Reset state
        @(negedge clk);
        check_val("rst_rdata", rdata, 32'h0);
        check_val("rst_addr",  32'(sram_addr), 32'h0);
        check_val("rst_dq",    32'(sram_dq_out), 32'h0);
        check_val("rst_dq_oe", 32'(sram_dq_oe), 32'h0);
        check_val("rst_bus_n", {29'h0, sram_we_n, sram_oe_n, sram_ce_n}, 32'h7);
        check_val("rst_ready", 32'(ready), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: store 0xDEADBEEF at 1024
        run_txn(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, -1, 32'h0, lat, we_low, oe_low, drv, rd);
        check_val("t1_lat",   32'(lat), 32'd5);
        check_val("t1_we",    32'(we_low), 32'd4);
        check_val("t1_mem0",  32'(mem[0]), 32'h0000_BEEF);
        check_val("t1_mem1",  32'(mem[1]), 32'h0000_DEAD);
        check_val("t1_rdata", rdata, 32'h0);

        // 2: load it back
        run_txn(1'b1, 1'b0, 32'd1024, 32'h0, -1, 32'h0, lat, we_low, oe_low, drv, rd);
        check_val("t2_lat",  32'(lat), 32'd5);
        check_val("t2_rd",   rd, 32'hDEAD_BEEF);
        check_val("t2_oe",   32'(oe_low), 32'd4);
        check_val("t2_drv",  32'(drv), 32'd0);

        // 3: idle for 10 cycles
        rdy_cnt = 0;
        ce_low  = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ready) rdy_cnt++;
            if (!sram_ce_n || !sram_we_n || !sram_oe_n || sram_dq_oe) ce_low++;
            @(posedge clk);
            #1;
        end
        check_val("t3_ready", 32'(rdy_cnt), 32'd10);
        check_val("t3_bus",   32'(ce_low), 32'd0);
        check_val("t3_rdata", rdata, 32'hDEAD_BEEF);

        // 4: load and store together -> store wins
        run_txn(1'b1, 1'b1, 32'd1028, 32'h1234_5678, -1, 32'h0, lat, we_low, oe_low, drv, rd);
        check_val("t4_lat",   32'(lat), 32'd5);
        check_val("t4_we",    32'(we_low), 32'd4);
        check_val("t4_mem2",  32'(mem[2]), 32'h0000_5678);
        check_val("t4_mem3",  32'(mem[3]), 32'h0000_1234);
        check_val("t4_rdata", rdata, 32'hDEAD_BEEF);

        // 5: request dropped and address changed in cycle 2 of a store
        run_txn(1'b0, 1'b1, 32'd1032, 32'hCAFE_F00D, 2, 32'd1040, lat, we_low, oe_low, drv, rd);
        check_val("t5_lat",  32'(lat), 32'd5);
        check_val("t5_mem4", 32'(mem[4]), 32'h0000_F00D);
        check_val("t5_mem5", 32'(mem[5]), 32'h0000_CAFE);
        check_val("t5_mem8", 32'(mem[8]), 32'h0);
        check_val("t5_mem9", 32'(mem[9]), 32'h0);

        // 6: reset during RD_HI of a load from 1028
        MEM_R_EN = 1'b1;
        addr     = 32'd1028;
        repeat (3) @(posedge clk);
        #2;
        check_val("t6_pre_oe", 32'(sram_oe_n), 32'h0);
        check_val("t6_pre_ad", 32'(sram_addr), 32'h3);
        rst = 1'b0;
        #1;
        check_val("t6_rdata", rdata, 32'h0);
        check_val("t6_addr",  32'(sram_addr), 32'h0);
        check_val("t6_dq",    32'(sram_dq_out), 32'h0);
        check_val("t6_bus",   {28'h0, sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n}, 32'h7);
        check_val("t6_ready", 32'(ready), 32'h0);
        MEM_R_EN = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_txn(1'b1, 1'b0, 32'd1028, 32'h0, -1, 32'h0, lat, we_low, oe_low, drv, rd);
        check_val("t6_lat", 32'(lat), 32'd5);
        check_val("t6_rd",  rd, 32'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
